// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter only has to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full-adder cell shared by the serial and ripple adders.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Carry
);

    assign Sum   = A ^ B ^ Cin;
    assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell reused for WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             Ovf,
`endif
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             r_state;
    state_e             w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_start_ready;
    logic               r_done_valid;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               w_fa_sum;
    logic               w_fa_carry;
    logic               w_accept;
    logic               w_last;
    logic               w_release;
    logic [WIDTH-1:0]   w_sum_next;

    fulladder u_fa (
        .A     (r_a_sh[0]),
        .B     (r_b_sh[0]),
        .Cin   (r_c),
        .Sum   (w_fa_sum),
        .Carry (w_fa_carry)
    );

    assign w_accept   = (r_state == IDLE) && start_valid && r_start_ready;
    assign w_last     = (r_state == RUN) && (r_cnt == CNT_LAST);
    assign w_release  = (r_state == DONE) && r_done_valid && done_ready;
    assign w_sum_next = {w_fa_sum, {(WIDTH-1){1'b0}}} | (r_sum_sh >> 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand shifters, carry feedback and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh <= A;
            r_b_sh <= B;
            r_c    <= Cin;
            r_cnt  <= '0;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> 1'b1;
            r_b_sh   <= r_b_sh >> 1'b1;
            r_sum_sh <= w_sum_next;
            r_c      <= w_fa_carry;
            // Wrap on the last bit so the counter never leaves 0..WIDTH-1.
            r_cnt    <= w_last ? '0 : (r_cnt + CNT_ONE);
        end
    end

    // Handshake flags and result word, all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_ready <= 1'b0;
            r_done_valid  <= 1'b0;
            r_sum         <= '0;
            r_carry       <= 1'b0;
        end else begin
            r_start_ready <= (w_next_state == IDLE);
            r_done_valid  <= (w_next_state == DONE);
            if (w_last) begin
                r_sum   <= w_sum_next;
                r_carry <= w_fa_carry;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_c is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_c ^ w_fa_carry;
        end
    end

    assign Ovf = r_ovf;
`endif

    assign start_ready = r_start_ready;
    assign done_valid  = r_done_valid;
    assign Sum         = r_sum;
    assign Carry       = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sv8, sr8, cin8, c8, dv8, dr8;
    logic [7:0] a8, b8, s8;
    logic       sv2, sr2, cin2, c2, dv2, dr2;
    logic [1:0] a2, b2, s2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
        .A(a8), .B(b8), .Cin(cin8), .Sum(s8), .Carry(c8),
`ifdef SERIAL_ADDER_OVF_EN
        .Ovf(ovf8),
`endif
        .done_valid(dv8), .done_ready(dr8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
        .A(a2), .B(b2), .Cin(cin2), .Sum(s2), .Carry(c2),
`ifdef SERIAL_ADDER_OVF_EN
        .Ovf(ovf2),
`endif
        .done_valid(dv2), .done_ready(dr2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation with done_ready high; operands are scrambled after accept.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] es, input logic ec, input logic eovf);
        int n;
        n = 0;
        while (!sr8 && n < 50) begin tick; n++; end
        check_eq("sr8_idle", 64'(sr8), 64'd1);
        a8 = a; b8 = b; cin8 = cin; sv8 = 1'b1;
        tick;
        sv8 = 1'b0;
        check_eq("sr8_busy", 64'(sr8), 64'd0);
        a8 = ~a; b8 = ~b; cin8 = ~cin;
        n = 0;
        while (!dv8 && n < 40) begin tick; n++; end
        check_eq("lat8", 64'(n), 64'd8);
        check_eq("sum8", 64'(s8), 64'(es));
        check_eq("carry8", 64'(c8), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("ovf8", 64'(ovf8), 64'(eovf));
`else
        if (eovf === 1'bx) $display("unused ovf expectation");
`endif
        tick;
        check_eq("dv8_drop", 64'(dv8), 64'd0);
        check_eq("sr8_back", 64'(sr8), 64'd1);
    endtask

    // One WIDTH=2 operation with done_ready high.
    task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic cin,
                           input logic [1:0] es, input logic ec);
        int n;
        n = 0;
        while (!sr2 && n < 50) begin tick; n++; end
        check_eq("sr2_idle", 64'(sr2), 64'd1);
        a2 = a; b2 = b; cin2 = cin; sv2 = 1'b1;
        tick;
        sv2 = 1'b0;
        a2 = ~a; b2 = ~b; cin2 = ~cin;
        n = 0;
        while (!dv2 && n < 40) begin tick; n++; end
        check_eq("lat2", 64'(n), 64'd2);
        check_eq("sum2", 64'(s2), 64'(es));
        check_eq("carry2", 64'(c2), 64'(ec));
        tick;
        check_eq("dv2_drop", 64'(dv2), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen_dv;
        rst = 1'b1;
        sv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; dr8 = 1'b1;
        sv2 = 1'b0; a2 = 2'd0;  b2 = 2'd0;  cin2 = 1'b0; dr2 = 1'b1;
        tick; tick;
        check_eq("rst_sr8", 64'(sr8), 64'd0);
        check_eq("rst_dv8", 64'(dv8), 64'd0);
        check_eq("rst_sum8", 64'(s8), 64'd0);
        check_eq("rst_carry8", 64'(c8), 64'd0);
        check_eq("rst_sr2", 64'(sr2), 64'd0);
        rst = 1'b0;
        tick;
        check_eq("rel_sr8", 64'(sr8), 64'd1);

        // Hand-computed W=8 vectors: {Carry,Sum} = A+B+Cin; last arg is signed overflow
        run_op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
        run_op8(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);
        run_op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Backpressure with ignored start pulses and operand changes
        dr8 = 1'b0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sv8 = 1'b1;
        tick;
        sv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sv8 = 1'b1; tick; sv8 = 1'b0; tick;
        end
        n = 0;
        while (!dv8 && n < 40) begin tick; n++; end
        for (int i = 0; i < 20; i++) begin
            sv8 = i[0];
            check_eq("bp_dv8", 64'(dv8), 64'd1);
            check_eq("bp_sum8", 64'(s8), 64'h46);
            check_eq("bp_carry8", 64'(c8), 64'd0);
            check_eq("bp_sr8", 64'(sr8), 64'd0);
            tick;
        end
        sv8 = 1'b0;
        dr8 = 1'b1;
        tick;
        check_eq("bp_dv8_drop", 64'(dv8), 64'd0);
        check_eq("bp_sr8_back", 64'(sr8), 64'd1);

        // Reset while cnt==3 aborts the operation
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; sv8 = 1'b1;
        tick;
        sv8 = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        check_eq("abort_sr8", 64'(sr8), 64'd0);
        check_eq("abort_dv8", 64'(dv8), 64'd0);
        check_eq("abort_sum8", 64'(s8), 64'd0);
        check_eq("abort_carry8", 64'(c8), 64'd0);
        rst = 1'b0;
        seen_dv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (dv8) seen_dv = 1'b1;
        end
        check_eq("abort_no_dv8", 64'(seen_dv), 64'd0);
        check_eq("abort_sr8_idle", 64'(sr8), 64'd1);
        run_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // Hand-computed W=2 back-to-back vectors
        run_op2(2'd3, 2'd3, 1'b1, 2'd3, 1'b1);
        run_op2(2'd1, 2'd1, 1'b0, 2'd2, 1'b0);
        run_op2(2'd2, 2'd3, 1'b0, 2'd1, 1'b1);
        run_op2(2'd0, 2'd0, 1'b1, 2'd1, 1'b0);
        run_op2(2'd3, 2'd0, 1'b0, 2'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
